fetch_unit: RTL

Instruction-fetch stage, directly upstream of the fetch/execute pipeline register. It owns the PC and fetches one instruction at a time from an instruction memory with variable latency. It presents the instruction together with `PC` and `nextPC` (PC+4), or a bubble, to decode and the fetch/execute register. It honours hazard stalls, branch/jump redirects and freezes on a halt word.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/fetch_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding and instruction constants.
package pipeline_pkg;

    typedef enum logic [2:0] {
        ST_ISSUE = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// presents a registered instruction/PC/nextPC or bubble to decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// ISSUE | request strobe high, address = pc
// WAIT  | request outstanding, waiting for imem_rvalid
// HOLD  | response parked in the 1-entry buffer while decode is stalled
// DRAIN | request outstanding but flushed by a redirect; response dropped
// HALT  | halt word fetched, no further requests until a redirect
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        in_stall,
    input  logic        in_redirect,
    input  logic [31:0] in_redirect_pc,
    output logic [31:0] out_insn,
    output logic [31:0] out_PC,
    output logic [31:0] out_nextPC,
    output logic        out_bubble,
    output logic        out_halted
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  buf_data, buf_data_n;
    logic [31:0]  insn_n, pc_o_n, next_o_n;
    logic         bubble_n, halted_n;
    logic         load;
    logic [31:0]  load_word;

    assign imem_req  = (state == ST_ISSUE);
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ISSUE;
            pc         <= RESET_PC;
            buf_data   <= '0;
            out_insn   <= NOP_INSN;
            out_PC     <= '0;
            out_nextPC <= '0;
            out_bubble <= 1'b1;
            out_halted <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            buf_data   <= buf_data_n;
            out_insn   <= insn_n;
            out_PC     <= pc_o_n;
            out_nextPC <= next_o_n;
            out_bubble <= bubble_n;
            out_halted <= halted_n;
        end
    end

    // The buffer counts as full exactly while in HOLD, so no separate valid bit.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        buf_data_n = buf_data;
        insn_n     = out_insn;
        pc_o_n     = out_PC;
        next_o_n   = out_nextPC;
        bubble_n   = out_bubble;
        halted_n   = out_halted;
        load       = 1'b0;
        load_word  = imem_rdata;

        if (in_redirect) begin
            pc_n     = in_redirect_pc & ~32'h3;
            insn_n   = NOP_INSN;
            bubble_n = 1'b1;
            halted_n = 1'b0;
            case (state)
                ST_ISSUE: state_n = ST_DRAIN;
                ST_WAIT:  state_n = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                ST_HOLD:  state_n = ST_ISSUE;
                ST_HALT:  state_n = ST_ISSUE;
                ST_DRAIN: state_n = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                default:  state_n = ST_ISSUE;
            endcase
        end else begin
            if (!in_stall) begin
                insn_n   = NOP_INSN;
                bubble_n = 1'b1;
            end
            case (state)
                ST_ISSUE: state_n = ST_WAIT;
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (in_stall) begin
                            buf_data_n = imem_rdata;
                            state_n    = ST_HOLD;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!in_stall) begin
                        load      = 1'b1;
                        load_word = buf_data;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) state_n = ST_ISSUE;
                end
                ST_HALT:  state_n = ST_HALT;
                default:  state_n = ST_ISSUE;
            endcase

            if (load) begin
                insn_n   = load_word;
                pc_o_n   = pc;
                next_o_n = pc + 32'd4;
                bubble_n = 1'b0;
                pc_n     = pc + 32'd4;
                if (load_word == HALT_WORD) begin
                    state_n  = ST_HALT;
                    halted_n = 1'b1;
                end else begin
                    state_n  = ST_ISSUE;
                end
            end
        end
    end

endmodule
